// File: rtl/add8u_err_profiler.sv
// add8u_err_profiler: exhaustive error characterisation of one approximate
// W-bit unsigned adder. Sweeps every (A, B) pair, compares the adder output
// against the exact sum and accumulates error count, error sum, worst-case
// error and squared-error sum.
module add8u_err_profiler #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    output logic           busy,
    output logic           done,
    output logic [W-1:0]   op_a,
    output logic [W-1:0]   op_b,
    input  logic [W:0]     approx_sum,
    output logic [2*W:0]   err_count,
    output logic [3*W:0]   err_sum,
    output logic [W:0]     wce,
    output logic [4*W+1:0] sq_err_sum
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SWEEP = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]     r_state;
    logic [2*W-1:0] r_cnt;
    logic [W:0]     r_e_q;
    logic           r_v_q;
    logic [2*W:0]   r_err_count;
    logic [3*W:0]   r_err_sum;
    logic [W:0]     r_wce;
    logic [4*W+1:0] r_sq_err_sum;

    logic             w_accept;
    logic             w_last;
    logic [W:0]       w_exact;
    logic [W:0]       w_e;
    logic [2*W+1:0]   w_e_ext;
    logic [2*W+1:0]   w_e_sq;

    assign w_accept = (r_state == S_IDLE) && start;
    assign w_last   = (r_cnt == '1);

    // op_a is the fast index, op_b the slow one
    assign op_a = r_cnt[W-1:0];
    assign op_b = r_cnt[2*W-1:W];

    assign w_exact = {1'b0, op_a} + {1'b0, op_b};

    // Absolute error, ordered subtraction so no sign bit is needed
    assign w_e = (approx_sum >= w_exact) ? (approx_sum - w_exact)
                                         : (w_exact - approx_sum);

    // Max error 2^(W+1)-1, so its square fits in 2W+2 bits
    assign w_e_ext = {{(W+1){1'b0}}, r_e_q};
    assign w_e_sq  = w_e_ext * w_e_ext;

    assign busy       = (r_state == S_SWEEP) || (r_state == S_DRAIN);
    assign done       = (r_state == S_DONE);
    assign err_count  = r_err_count;
    assign err_sum    = r_err_sum;
    assign wce        = r_wce;
    assign sq_err_sum = r_sq_err_sum;

    // Control FSM: IDLE -> SWEEP -> DRAIN -> DONE -> IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (start)  r_state <= S_SWEEP;
                S_SWEEP: if (w_last) r_state <= S_DRAIN;
                S_DRAIN: r_state <= S_DONE;
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Pair counter; stops on all-ones so operands hold (max, max) after the sweep
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= '0;
        end else if ((r_state == S_SWEEP) && !w_last) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Stage 1: register the absolute error and its valid flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_e_q <= '0;
            r_v_q <= 1'b0;
        end else begin
            r_e_q <= w_e;
            r_v_q <= (r_state == S_SWEEP);
        end
    end

    // Stage 2: accumulate statistics; cleared by an accepted start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_count  <= '0;
            r_err_sum    <= '0;
            r_wce        <= '0;
            r_sq_err_sum <= '0;
        end else if (w_accept) begin
            r_err_count  <= '0;
            r_err_sum    <= '0;
            r_wce        <= '0;
            r_sq_err_sum <= '0;
        end else if (r_v_q) begin
            r_err_count  <= r_err_count + {{(2*W){1'b0}}, |r_e_q};
            r_err_sum    <= r_err_sum + {{(2*W){1'b0}}, r_e_q};
            r_sq_err_sum <= r_sq_err_sum + {{(2*W){1'b0}}, w_e_sq};
            if (r_e_q > r_wce) begin
                r_wce <= r_e_q;
            end
        end
    end

endmodule

// File: tb/tb_add8u_err_profiler.sv
// Self-checking bench for add8u_err_profiler. A W=4 instance runs the
// scenario set with several adder stubs; a W=8 instance runs one full
// zero-stub sweep in parallel against the known reference numbers.
module tb_add8u_err_profiler;

    localparam int WS = 4;
    localparam int NS = 1 << (2 * WS);
    localparam int WB = 8;
    localparam int NB = 1 << (2 * WB);

    typedef struct {
        longint unsigned cnt;
        longint unsigned sum;
        longint unsigned wce;
        longint unsigned sq;
    } res_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    res_t sb_s[$];
    res_t sb_b[$];

    // small instance
    logic            rst_n_s, s_start, s_busy, s_done;
    logic [WS-1:0]   s_op_a, s_op_b;
    logic [WS:0]     s_approx;
    logic [2*WS:0]   s_err_count;
    logic [3*WS:0]   s_err_sum;
    logic [WS:0]     s_wce;
    logic [4*WS+1:0] s_sq;
    int              mode;

    // big instance
    logic            rst_n_b, b_start, b_busy, b_done;
    logic [WB-1:0]   b_op_a, b_op_b;
    logic [WB:0]     b_approx;
    logic [2*WB:0]   b_err_count;
    logic [3*WB:0]   b_err_sum;
    logic [WB:0]     b_wce;
    logic [4*WB+1:0] b_sq;

    add8u_err_profiler #(.W(WS)) u_dut_s (
        .clk(clk), .rst_n(rst_n_s), .start(s_start), .busy(s_busy), .done(s_done),
        .op_a(s_op_a), .op_b(s_op_b), .approx_sum(s_approx),
        .err_count(s_err_count), .err_sum(s_err_sum), .wce(s_wce), .sq_err_sum(s_sq)
    );

    add8u_err_profiler #(.W(WB)) u_dut_b (
        .clk(clk), .rst_n(rst_n_b), .start(b_start), .busy(b_busy), .done(b_done),
        .op_a(b_op_a), .op_b(b_op_b), .approx_sum(b_approx),
        .err_count(b_err_count), .err_sum(b_err_sum), .wce(b_wce), .sq_err_sum(b_sq)
    );

    // Adder stubs: 0 exact, 1 LSB dropped, 2 constant zero, 3 constant all-ones
    function automatic logic [WS:0] stub_s(input int m, input int a, input int b);
        logic [WS:0] ex;
        ex = (WS + 1)'(a + b);
        case (m)
            0:       return ex;
            1:       begin ex[0] = 1'b0; return ex; end
            2:       return '0;
            default: return '1;
        endcase
    endfunction

    always_comb s_approx = stub_s(mode, int'(s_op_a), int'(s_op_b));
    assign b_approx = '0;

    function automatic res_t model_s(input int m);
        res_t r;
        int   ex, ap, e;
        r = '{default: 0};
        for (int b = 0; b < (1 << WS); b++) begin
            for (int a = 0; a < (1 << WS); a++) begin
                ex = a + b;
                ap = int'(stub_s(m, a, b));
                e  = (ap > ex) ? ap - ex : ex - ap;
                if (e != 0) r.cnt++;
                r.sum += longint'(e);
                if (longint'(e) > r.wce) r.wce = longint'(e);
                r.sq += longint'(e * e);
            end
        end
        return r;
    endfunction

    task automatic check_eq(input string tag, input longint unsigned got, input longint unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One W=4 sweep; repulse re-asserts start mid-sweep and on the done
    // cycle; abort_at >= 0 pulls reset at that cycle and abandons the sweep.
    task automatic run_small(input int m, input bit repulse, input int abort_at);
        int   j;
        res_t r;
        mode    = m;
        s_start = 1'b1;
        sb_s.push_back(model_s(m));
        @(posedge clk);
        @(negedge clk);
        s_start = 1'b0;
        j = 0;
        check_eq("s_busy_rise", 64'(s_busy), 64'd1);
        check_eq("s_acc_clear", 64'({s_err_count, s_err_sum, s_wce, s_sq}), 64'd0);
        while (s_done !== 1'b1 && j < 4 * NS) begin
            if (j == abort_at) begin
                rst_n_s = 1'b0;
                #1;
                check_eq("s_rst_async",
                         64'({s_busy, s_done, s_op_a, s_op_b, s_err_count, s_err_sum, s_wce, s_sq}),
                         64'd0);
                @(negedge clk);
                rst_n_s = 1'b1;
                check_eq("s_rst_idle", 64'({s_busy, s_done}), 64'd0);
                void'(sb_s.pop_front());
                return;
            end
            if (j < NS) check_eq("s_op_order", 64'({s_op_b, s_op_a}), 64'(j));
            if (j == NS) check_eq("s_busy_drain", 64'(s_busy), 64'd1);
            if (repulse && j == 100) s_start = 1'b1;
            if (repulse && j == 101) s_start = 1'b0;
            @(negedge clk);
            j++;
        end
        check_eq("s_done_latency", 64'(j), 64'(NS + 1));
        r = sb_s.pop_front();
        check_eq("s_err_count", 64'(s_err_count), r.cnt);
        check_eq("s_err_sum",   64'(s_err_sum),   r.sum);
        check_eq("s_wce",       64'(s_wce),       r.wce);
        check_eq("s_sq_err_sum", 64'(s_sq),       r.sq);
        if (repulse) s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        check_eq("s_idle_flags", 64'({s_busy, s_done}), 64'd0);
        check_eq("s_op_hold",    64'({s_op_b, s_op_a}), 64'(NS - 1));
        check_eq("s_hold_sum",   64'(s_err_sum), r.sum);
        check_eq("s_hold_sq",    64'(s_sq),      r.sq);
    endtask

    // One full W=8 zero-stub sweep against the reference figures
    task automatic run_big();
        int   j;
        res_t r;
        b_start = 1'b1;
        sb_b.push_back('{64'd65535, 64'd16711680, 64'd510, 64'd4977295360});
        @(posedge clk);
        @(negedge clk);
        b_start = 1'b0;
        j = 0;
        check_eq("b_busy_rise", 64'(b_busy), 64'd1);
        while (b_done !== 1'b1 && j < NB + 100) begin
            if (j < 3 || j == 256 || j == NB - 1)
                check_eq("b_op_order", 64'({b_op_b, b_op_a}), 64'(j));
            @(negedge clk);
            j++;
        end
        check_eq("b_done_latency", 64'(j), 64'(NB + 1));
        r = sb_b.pop_front();
        check_eq("b_err_count",  64'(b_err_count), r.cnt);
        check_eq("b_err_sum",    64'(b_err_sum),   r.sum);
        check_eq("b_wce",        64'(b_wce),       r.wce);
        check_eq("b_sq_err_sum", 64'(b_sq),        r.sq);
        @(negedge clk);
        check_eq("b_idle_flags", 64'({b_busy, b_done}), 64'd0);
        check_eq("b_op_hold",    64'({b_op_b, b_op_a}), 64'(NB - 1));
    endtask

    initial begin
        rst_n_s = 1'b0;
        rst_n_b = 1'b0;
        s_start = 1'b0;
        b_start = 1'b0;
        mode    = 0;
        repeat (3) @(negedge clk);
        check_eq("s_reset_state",
                 64'({s_busy, s_done, s_op_a, s_op_b, s_err_count, s_err_sum, s_wce, s_sq}), 64'd0);
        check_eq("b_reset_flags", 64'({b_busy, b_done, b_op_a, b_op_b, b_wce}), 64'd0);
        check_eq("b_reset_acc",   64'({b_err_count, b_err_sum}), 64'd0);
        check_eq("b_reset_sq",    64'(b_sq), 64'd0);
        rst_n_s = 1'b1;
        rst_n_b = 1'b1;
        @(negedge clk);
        fork
            run_big();
            begin
                run_small(0, 1'b0, -1);
                run_small(1, 1'b0, -1);
                run_small(2, 1'b0, -1);
                run_small(3, 1'b0, -1);
                run_small(0, 1'b1, -1);
                run_small(1, 1'b0, -1);
                run_small(2, 1'b0, 120);
                run_small(2, 1'b0, -1);
            end
        join
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
